// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] HDR_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    HI      = 3'd2,
    LO      = 3'd3,
    CSUM    = 3'd4,
    START   = 3'd5,
    RUNNING = 3'd6
  } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);
  logic                in_valid;
  logic [BYTE_W-1:0]   in_data;
  logic                in_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_W-1:0]   mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Frames a byte stream into 16-bit words, writes them from address 0,
// verifies the XOR checksum and then releases the processor reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned     ADDR_W = 8,
  parameter logic [7:0]      HDR    = HDR_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  prog_loader_if.slave   bus,
  input  logic           reload,
  output logic           cpu_rst,
  output logic           RUN,
  output logic           done,
  output logic           err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CMP_W = (CNT_W > BYTE_W) ? CNT_W : BYTE_W;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   csum_q, csum_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                in_ready_c;
  logic                xfer_c;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic                len_bad_c;

  // Byte acceptance depends only on state so a source never sees ready flicker mid-cycle.
  always_comb begin
    in_ready_c = !rst && (state_q inside {IDLE, LEN, HI, LO, CSUM});
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    hi_d        = hi_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_d   = cpu_rst_q;
    run_d       = run_q;
    done_d      = done_q;
    err_d       = err_q;

    xfer_c    = bus.in_valid && in_ready_c;
    cnt_inc_c = cnt_q + CNT_W'(1);
    // Lengths beyond the addressable memory are only possible for narrow address buses.
    len_bad_c = (bus.in_data == '0) || (32'(bus.in_data) > (32'd1 << ADDR_W));

    case (state_q)
      IDLE: begin
        if (xfer_c && bus.in_data == HDR) begin
          state_d = LEN;
          err_d   = 1'b0;
          done_d  = 1'b0;
        end
      end
      LEN: begin
        if (xfer_c) begin
          n_d = bus.in_data;
          if (len_bad_c) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            csum_d  = '0;
            state_d = HI;
          end
        end
      end
      HI: begin
        if (xfer_c) begin
          hi_d    = bus.in_data;
          csum_d  = csum_q ^ bus.in_data;
          state_d = LO;
        end
      end
      LO: begin
        if (xfer_c) begin
          csum_d      = csum_q ^ bus.in_data;
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = {hi_q, bus.in_data};
          cnt_d       = cnt_inc_c;
          state_d     = (CMP_W'(cnt_inc_c) == CMP_W'(n_q)) ? CSUM : HI;
        end
      end
      CSUM: begin
        if (xfer_c) begin
          if (bus.in_data == csum_q) begin
            done_d  = 1'b1;
            state_d = START;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      START: begin
        cpu_rst_d = 1'b0;
        run_d     = 1'b1;
        state_d   = RUNNING;
      end
      RUNNING: begin
        if (reload) begin
          cpu_rst_d = 1'b1;
          run_d     = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        cpu_rst_d = 1'b1;
        run_d     = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      hi_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      hi_q        <= hi_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      run_q       <= run_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst       = cpu_rst_q;
  assign RUN           = run_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized frames for prog_loader, checked against a frame-level model.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 8;
  localparam logic [7:0]  HDR    = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic reload;
  logic cpu_rst, run, done, err;

  int errors = 0;
  int checks = 0;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .HDR(HDR)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .reload  (reload),
    .cpu_rst (cpu_rst),
    .RUN     (run),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; a write is expected right after the edge only when flagged.
  task automatic tick(input bit exp_we, input logic [7:0] ea, input logic [15:0] ed);
    @(posedge clk);
    #1;
    chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
    if (exp_we) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_lo, input logic [7:0] ea,
                           input logic [15:0] ed, input int max_gap);
    int  gap;
    bit  got;
    bit  rdy;
    gap = int'($urandom_range(32'(max_gap), 0));
    bus.in_valid = 1'b0;
    repeat (gap) tick(1'b0, 8'h00, 16'h0000);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      rdy = bus.in_ready;
      tick(rdy && is_lo, ea, ed);
      got = rdy;
    end
    chk("handshake", 32'(got), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input bit e_rdy, input bit e_crst,
                               input bit e_run, input bit e_done, input bit e_err);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(e_rdy));
    chk({tag, ".cpu_rst"},  32'(cpu_rst),      32'(e_crst));
    chk({tag, ".RUN"},      32'(run),          32'(e_run));
    chk({tag, ".done"},     32'(done),         32'(e_done));
    chk({tag, ".err"},      32'(err),          32'(e_err));
  endtask

  // Model: words are written to 0..N-1; checksum is the XOR of all payload bytes.
  task automatic send_frame(input logic [15:0] words[$], input bit bad, input int max_gap);
    int         n;
    logic [7:0] cs;
    n  = words.size();
    cs = 8'h00;
    foreach (words[k]) cs = cs ^ words[k][15:8] ^ words[k][7:0];
    if (bad) cs = cs ^ 8'h01;
    send_byte(HDR, 1'b0, 8'h00, 16'h0, max_gap);
    send_byte(8'(n), 1'b0, 8'h00, 16'h0, max_gap);
    foreach (words[k]) begin
      send_byte(words[k][15:8], 1'b0, 8'h00, 16'h0, max_gap);
      send_byte(words[k][7:0], 1'b1, 8'(k), words[k], max_gap);
    end
    send_byte(cs, 1'b0, 8'h00, 16'h0, max_gap);
    chk("addr_hold", 32'(bus.mem_addr), 32'(n - 1));
    if (bad) begin
      check_outputs("rejected", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 8'h00, 16'h0);
      check_outputs("rejected_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    end else begin
      check_outputs("start", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 8'h00, 16'h0);
      check_outputs("running", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reload(input bit e_done, input bit e_err);
    reload = 1'b1;
    tick(1'b0, 8'h00, 16'h0);
    reload = 1'b0;
    check_outputs("reload", 1'b1, 1'b1, 1'b0, e_done, e_err);
  endtask

  initial begin
    logic [15:0] w[$];
    bit          bad;
    int          n;

    rst          = 1'b1;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst.mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check_outputs("rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(1'b0, 8'h00, 16'h0);
    check_outputs("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Good two-word frame, back to back.
    w = '{16'h1234, 16'hABCD};
    send_frame(w, 1'b0, 0);

    // Bytes offered while running are not taken.
    bus.in_valid = 1'b1;
    bus.in_data  = HDR;
    repeat (3) tick(1'b0, 8'h00, 16'h0);
    bus.in_valid = 1'b0;
    check_outputs("run_ignore", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    do_reload(1'b1, 1'b0);
    w = '{16'h0007};
    send_frame(w, 1'b0, 0);
    do_reload(1'b1, 1'b0);

    // Reload outside RUNNING has no effect.
    do_reload(1'b1, 1'b0);

    // Bad checksum, then a good frame clears err and restarts at 0.
    w = '{16'h1234, 16'hABCD};
    send_frame(w, 1'b1, 0);
    w = '{16'h1234, 16'hABCD};
    send_frame(w, 1'b0, 0);
    do_reload(1'b1, 1'b0);

    // Noise before the header is dropped.
    send_byte(8'h00, 1'b0, 8'h00, 16'h0, 0);
    send_byte(8'hFF, 1'b0, 8'h00, 16'h0, 0);
    send_byte(8'h5A, 1'b0, 8'h00, 16'h0, 0);
    check_outputs("noise", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    w = '{16'hBEEF};
    send_frame(w, 1'b0, 0);
    do_reload(1'b1, 1'b0);

    // Zero length is rejected without writes.
    send_byte(HDR, 1'b0, 8'h00, 16'h0, 0);
    send_byte(8'h00, 1'b0, 8'h00, 16'h0, 0);
    check_outputs("len0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 16'h0);

    // Same frame with random valid gaps.
    w = '{16'h1234, 16'hABCD};
    send_frame(w, 1'b0, 5);
    do_reload(1'b1, 1'b0);

    // Reset after the first word of a three-word frame.
    send_byte(HDR, 1'b0, 8'h00, 16'h0, 0);
    send_byte(8'h03, 1'b0, 8'h00, 16'h0, 0);
    send_byte(8'h11, 1'b0, 8'h00, 16'h0, 0);
    send_byte(8'h22, 1'b1, 8'h00, 16'h1122, 0);
    send_byte(8'h33, 1'b0, 8'h00, 16'h0, 0);
    rst = 1'b1;
    tick(1'b0, 8'h00, 16'h0);
    chk("midrst.mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("midrst.mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check_outputs("midrst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 16'h0);
    rst = 1'b0;
    tick(1'b0, 8'h00, 16'h0);
    w = '{16'h5566, 16'h7788};
    send_frame(w, 1'b0, 2);

    // Reset while running.
    rst = 1'b1;
    tick(1'b0, 8'h00, 16'h0);
    check_outputs("rst_run", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(1'b0, 8'h00, 16'h0);

    // Longest frame the length byte allows.
    w = {};
    for (int k = 0; k < 255; k++) w.push_back(16'($urandom));
    send_frame(w, 1'b0, 0);
    do_reload(1'b1, 1'b0);

    // Random frames, some with corrupted checksums.
    for (int r = 0; r < 12; r++) begin
      n = int'($urandom_range(8, 1));
      w = {};
      for (int k = 0; k < n; k++) w.push_back(16'($urandom));
      bad = ($urandom_range(3, 0) == 0);
      send_frame(w, bad, int'($urandom_range(3, 0)));
      if (!bad) do_reload(1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
